fft_addr_gen: RTL and testbench

FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_addr_gen_if.sv | 41 ++++
 rtl/fft_addr_dly.sv | 35 +++
 rtl/fft_addr_gen.sv | 176 +++++++++++++++++
 tb/tb_fft_addr_gen.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// FFT address generator shared types and helpers.
// State encoding, stage-width helper and legal parameter ranges.
package fft_pkg;

    localparam int LOG2N_MIN    = 3;
    localparam int LOG2N_MAX    = 14;
    localparam int BFLY_LAT_MIN = 1;
    localparam int BFLY_LAT_MAX = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_UNLOAD,
        ST_DONE
    } fft_state_t;

    // Width of the stage index for a given transform order.
    function automatic int stage_w(input int log2n);
        return $clog2(log2n + 1);
    endfunction

endpackage

// File: rtl/fft_addr_gen_if.sv
// FFT address generator control and address bus.
// master drives start/stall, slave is the generator.
interface fft_addr_gen_if
    import fft_pkg::*;
#(
    parameter int LOG2N = 11
);
    localparam int SW = stage_w(LOG2N);

    logic             start;
    logic             stall;
    logic             busy;
    logic             done;
    logic [SW-1:0]    stage;
    logic             rd_valid;
    logic [LOG2N-1:0] rd_addr0;
    logic [LOG2N-1:0] rd_addr1;
    logic [LOG2N-2:0] tf_addr;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr0;
    logic [LOG2N-1:0] wr_addr1;
    logic             ul_valid;
    logic [LOG2N-1:0] ul_addr;

    modport master (
        output start, stall,
        input  busy, done, stage,
        input  rd_valid, rd_addr0, rd_addr1, tf_addr,
        input  wr_en, wr_addr0, wr_addr1,
        input  ul_valid, ul_addr
    );

    modport slave (
        input  start, stall,
        output busy, done, stage,
        output rd_valid, rd_addr0, rd_addr1, tf_addr,
        output wr_en, wr_addr0, wr_addr1,
        output ul_valid, ul_addr
    );

endinterface

// File: rtl/fft_addr_dly.sv
// Stall-aware delay line for {valid, addr0, addr1}.
// Advances only on non-stalled cycles; cleared by reset.
module fft_addr_dly #(
    parameter int AW  = 11,
    parameter int LAT = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall,
    input  logic          in_valid,
    input  logic [AW-1:0] in_a0,
    input  logic [AW-1:0] in_a1,
    output logic          out_valid,
    output logic [AW-1:0] out_a0,
    output logic [AW-1:0] out_a1
);
    localparam int W = 2 * AW + 1;

    logic [W-1:0] pipe [LAT];

    // Shift one slot per non-stalled cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++)
                pipe[i] <= '0;
        end else if (!stall) begin
            pipe[0] <= {in_valid, in_a0, in_a1};
            for (int i = 1; i < LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign {out_valid, out_a0, out_a1} = pipe[LAT-1];

endmodule

// File: rtl/fft_addr_gen.sv
// In-place radix-2 FFT read/write/twiddle address generator.
// Optional bit-reversed unload phase: FFT_ADDR_GEN_UNLOAD_EN.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N    = 11,
    parameter int BFLY_LAT = 3
) (
    input  logic          clock,
    input  logic          reset,
    fft_addr_gen_if.slave bus
);
    localparam int AW = LOG2N;
    localparam int TW = LOG2N - 1;
    localparam int SW = stage_w(LOG2N);

    localparam logic [AW-1:0] RUN_LAST = AW'((1 << TW) - 1);
    localparam logic [AW-1:0] GAP_LAST = AW'(BFLY_LAT - 1);
    localparam logic [SW-1:0] STG_LAST = SW'(LOG2N - 1);

    fft_state_t    state;
    logic [AW-1:0] cnt;
    logic [SW-1:0] stage;
    logic          busy_q;
    logic          done_q;

    logic          run;
    logic          rd_v;
    logic [AW-1:0] b_ext;
    logic [AW-1:0] span;
    logic [AW-1:0] mask;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [TW-1:0] tf;

    logic          wr_v;
    logic [AW-1:0] wa0;
    logic [AW-1:0] wa1;

    // Butterfly addressing: split b into group g and offset j.
    always_comb begin
        run   = (state == ST_RUN);
        rd_v  = run & ~bus.stall;
        b_ext = {1'b0, cnt[TW-1:0]};
        span  = AW'(1) << stage;
        mask  = span - AW'(1);
        a0    = ((b_ext & ~mask) << 1) | (b_ext & mask);
        a1    = a0 | span;
        tf    = TW'((b_ext & mask) << (TW - int'(stage)));
    end

    // Control FSM; stall freezes everything except IDLE and DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            stage  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        stage  <= '0;
                    end
                end
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (cnt == RUN_LAST) begin
                            state <= ST_GAP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (!bus.stall) begin
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            if (stage == STG_LAST) begin
`ifdef FFT_ADDR_GEN_UNLOAD_EN
                                state <= ST_UNLOAD;
`else
                                state  <= ST_DONE;
                                done_q <= 1'b1;
`endif
                            end else begin
                                state <= ST_RUN;
                                stage <= stage + SW'(1);
                            end
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                end
`ifdef FFT_ADDR_GEN_UNLOAD_EN
                ST_UNLOAD: begin
                    if (!bus.stall) begin
                        if (cnt == '1) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                end
`endif
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    stage  <= '0;
                    cnt    <= '0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    stage  <= '0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    fft_addr_dly #(
        .AW  (AW),
        .LAT (BFLY_LAT)
    ) u_dly (
        .clock     (clock),
        .reset     (reset),
        .stall     (bus.stall),
        .in_valid  (rd_v),
        .in_a0     (bus.rd_addr0),
        .in_a1     (bus.rd_addr1),
        .out_valid (wr_v),
        .out_a0    (wa0),
        .out_a1    (wa1)
    );

`ifdef FFT_ADDR_GEN_UNLOAD_EN
    logic          ul_run;
    logic [AW-1:0] ul_rev;

    // Bit-reversed unload index from the unload counter.
    always_comb begin
        ul_run = (state == ST_UNLOAD);
        ul_rev = '0;
        for (int i = 0; i < AW; i++)
            ul_rev[i] = cnt[AW-1-i];
    end

    assign bus.ul_valid = ul_run & ~bus.stall;
    assign bus.ul_addr  = ul_run ? ul_rev : '0;
`else
    assign bus.ul_valid = 1'b0;
    assign bus.ul_addr  = '0;
`endif

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.stage    = stage;
    assign bus.rd_valid = rd_v;
    assign bus.rd_addr0 = run ? a0 : '0;
    assign bus.rd_addr1 = run ? a1 : '0;
    assign bus.tf_addr  = run ? tf : '0;
    assign bus.wr_en    = wr_v & ~bus.stall;
    assign bus.wr_addr0 = wa0;
    assign bus.wr_addr1 = wa1;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen (N=8 lat 2, plus N=2048 lat 3).
// Handles builds with and without FFT_ADDR_GEN_UNLOAD_EN.
module tb_fft_addr_gen;

`ifdef FFT_ADDR_GEN_UNLOAD_EN
    localparam int UL_N  = 8;
    localparam int UL_NB = 2048;
`else
    localparam int UL_N  = 0;
    localparam int UL_NB = 0;
`endif
    localparam int BASE  = 19 + UL_N;
    localparam int BIG_D = 11 * (1024 + 3) + 1 + UL_NB;

    logic clock;
    logic reset;
    int   nvec;
    int   nerr;

    int e0 [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int e1 [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int et [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int eu [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_addr_gen_if #(.LOG2N(3))  f ();
    fft_addr_gen_if #(.LOG2N(11)) g ();

    fft_addr_gen #(
        .LOG2N    (3),
        .BFLY_LAT (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (f.slave)
    );

    fft_addr_gen #(
        .LOG2N    (11),
        .BFLY_LAT (3)
    ) dut_big (
        .clock (clock),
        .reset (reset),
        .bus   (g.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({f.busy, f.done, f.stage, f.rd_valid, f.rd_addr0,
                    f.rd_addr1, f.tf_addr, f.wr_en, f.wr_addr0,
                    f.wr_addr1, f.ul_valid, f.ul_addr});
    endfunction

    // One transform on the small DUT; start sampled at edge 0.
    task automatic run_xfer(input int st_at, input int st_len,
                            input int sb, input int exp_done);
        int rd_ns [12];
        int ns, ri, wi, dn, ul, dc;
        ns = 0; ri = 0; wi = 0; dn = 0; ul = 0; dc = -1;
        f.stall = (st_at == 1);
        f.start = 1'b1;
        @(posedge clock); #1;
        f.start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            f.stall = (c >= st_at && c < st_at + st_len);
            f.start = (c == sb);
            @(negedge clock);
            if (f.stall) begin
                chk("rd_valid_in_stall", f.rd_valid, 0);
                chk("wr_en_in_stall", f.wr_en, 0);
            end
            if (f.rd_valid) begin
                if (ri < 12) begin
                    if (ri % 4 == 0 && ri > 0)
                        chk("stage_order", wi, ri);
                    chk("rd_addr0", f.rd_addr0, e0[ri]);
                    chk("rd_addr1", f.rd_addr1, e1[ri]);
                    chk("tf_addr", f.tf_addr, et[ri]);
                    chk("stage", f.stage, ri / 4);
                    rd_ns[ri] = ns;
                end else begin
                    chk("rd_extra", ri, 11);
                end
                ri++;
            end
            if (f.wr_en) begin
                if (wi < 12) begin
                    chk("wr_addr0", f.wr_addr0, e0[wi]);
                    chk("wr_addr1", f.wr_addr1, e1[wi]);
                    chk("wr_latency", ns, rd_ns[wi] + 2);
                end else begin
                    chk("wr_extra", wi, 11);
                end
                wi++;
            end
            if (f.ul_valid) begin
                if (ul < 8) begin
                    chk("ul_addr", f.ul_addr, eu[ul]);
                    chk("ul_after_wr", wi, 12);
                end
                ul++;
            end
            if (f.done) begin
                dn++;
                dc = c;
                chk("busy_at_done", f.busy, 1);
            end
            if (!f.stall) ns++;
            @(posedge clock); #1;
            if (dn > 0) begin
                chk("busy_after_done", f.busy, 0);
                break;
            end
        end
        f.stall = 1'b0;
        f.start = 1'b0;
        chk("rd_count", ri, 12);
        chk("wr_count", wi, 12);
        chk("ul_count", ul, UL_N);
        chk("done_count", dn, 1);
        chk("done_cycle", dc, exp_done);
    endtask

    initial begin
        int dn, dc;
        nvec = 0;
        nerr = 0;
        reset = 1'b0;
        f.start = 1'b0; f.stall = 1'b0;
        g.start = 1'b0; g.stall = 1'b0;
        @(negedge clock);
        chk("reset_outs", outs(), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("release_outs", outs(), 0);
        chk("big_idle_busy", g.busy, 0);
        @(posedge clock); #1;

        // Plain run with a start pulse while busy.
        run_xfer(0, 0, 5, BASE);
        // Three stall cycles in the middle of stage 1.
        run_xfer(8, 3, 0, BASE + 3);
        // start and stall together in IDLE.
        run_xfer(1, 1, 0, BASE + 1);

        // Abort by reset at cycle 10.
        f.start = 1'b1;
        @(posedge clock); #1;
        f.start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clock); #1;
        end
        chk("busy_before_abort", f.busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_outs", outs(), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("abort_hold", outs(), 0);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("abort_release", outs(), 0);
        @(posedge clock); #1;
        run_xfer(0, 0, 0, BASE);

        // Large configuration.
        dn = 0;
        dc = -1;
        g.start = 1'b1;
        @(posedge clock); #1;
        for (int c = 1; c <= 14000; c++) begin
            g.start = (c == 100);
            @(negedge clock);
            if (c == 1) begin
                chk("big_rd0_c1", g.rd_addr0, 0);
                chk("big_rd1_c1", g.rd_addr1, 1);
            end
            if (c == 1025)
                chk("big_gap_valid", g.rd_valid, 0);
            if (c == 1031) begin
                chk("big_s1_rd0", g.rd_addr0, 5);
                chk("big_s1_rd1", g.rd_addr1, 7);
                chk("big_s1_tf", g.tf_addr, 512);
                chk("big_s1_stage", g.stage, 1);
            end
            if (c == 10276) begin
                chk("big_s10_rd0", g.rd_addr0, 5);
                chk("big_s10_rd1", g.rd_addr1, 1029);
                chk("big_s10_tf", g.tf_addr, 5);
                chk("big_s10_stage", g.stage, 10);
            end
            if (g.done) begin
                dn++;
                dc = c;
            end
            @(posedge clock); #1;
            if (dn > 0 && !g.busy) break;
        end
        g.start = 1'b0;
        chk("big_done_count", dn, 1);
        chk("big_done_cycle", dc, BIG_D);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
